mem_arbiter: RTL

//  Shares the single-port LC-3 DRAM between the instruction-fetch port (IF) and the data load/store port (D).

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_if.sv | 42 ++++
 rtl/mem_arb_rdpipe.sv | 30 +++
 rtl/mem_arbiter.sv | 133 +++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the LC-3 DRAM arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;
    localparam int REQ_ADDR_W = 16;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } rd_tag_t;

endpackage

// File: rtl/mem_arb_if.sv
// Request/return bus between the fetch port, the data port, the arbiter and the DRAM macro.
interface mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic                  IF_REQ;
    logic [REQ_ADDR_W-1:0] IF_ADDR;
    logic                  IF_GNT;
    logic                  IF_RVALID;
    logic [DATA_W-1:0]     IF_RDATA;

    logic                  D_REQ;
    logic                  D_WE;
    logic [REQ_ADDR_W-1:0] D_ADDR;
    logic [DATA_W-1:0]     D_WDATA;
    logic                  D_GNT;
    logic                  D_RVALID;
    logic [DATA_W-1:0]     D_RDATA;

    logic [ADDR_W-1:0]     MEM_ADDR;
    logic [DATA_W-1:0]     MEM_WDATA;
    logic                  MEM_WE;
    logic [DATA_W-1:0]     MEM_RDATA;

    // Arbiter view.
    modport slave (
        input  IF_REQ, IF_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, MEM_RDATA,
        output IF_GNT, IF_RVALID, IF_RDATA, D_GNT, D_RVALID, D_RDATA,
        output MEM_ADDR, MEM_WDATA, MEM_WE
    );

    // Requester and DRAM view.
    modport master (
        output IF_REQ, IF_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, MEM_RDATA,
        input  IF_GNT, IF_RVALID, IF_RDATA, D_GNT, D_RVALID, D_RDATA,
        input  MEM_ADDR, MEM_WDATA, MEM_WE
    );

endinterface

// File: rtl/mem_arb_rdpipe.sv
// Read-return tracker: DEPTH-stage shift register of {valid, owner} tags matching the DRAM read latency.
module mem_arb_rdpipe
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    CLK,
    input  logic    RST_N,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t [DEPTH-1:0] stage;

    // NOTE: unlike a data RAM, every stage is reset: a stale valid bit would fire a bogus RVALID after reset.
    // State is updated with non-blocking assignments so each stage samples its predecessor's old value.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stage <= '0;
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// Single-port LC-3 DRAM arbiter between instruction fetch and data load/store.
// Define MEM_ARB_RR_EN for round-robin; otherwise fixed D priority with an IF starvation guard.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_LAT     = 1,
    parameter int STARVE_LIM = 4
) (
    input logic      CLK,
    input logic      RST_N,
    mem_arb_if.slave bus
);

    owner_e            winner;
    logic              any_win;
    logic              if_gnt;
    logic              d_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic [ADDR_W-1:0] addr_q;
    rd_tag_t           tag_in;
    rd_tag_t           tag_head;
    logic              if_rvalid;
    logic              d_rvalid;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              unused_addr_bits;

`ifdef MEM_ARB_RR_EN
    owner_e last_owner;
`else
    localparam int CNT_W = $clog2(STARVE_LIM + 1);
    logic [CNT_W-1:0] starve_cnt;
    logic             if_starved;

    assign if_starved = (starve_cnt == CNT_W'(STARVE_LIM));
`endif

    // NOTE: defaults come first so every path assigns every output and no latch is inferred.
    always_comb begin
        any_win = 1'b0;
        winner  = OWN_IF;
`ifdef MEM_ARB_RR_EN
        if (bus.IF_REQ && bus.D_REQ) begin
            any_win = 1'b1;
            winner  = (last_owner == OWN_IF) ? OWN_D : OWN_IF;
        end else if (bus.D_REQ) begin
            any_win = 1'b1;
            winner  = OWN_D;
        end else if (bus.IF_REQ) begin
            any_win = 1'b1;
            winner  = OWN_IF;
        end
`else
        if (bus.D_REQ && !(bus.IF_REQ && if_starved)) begin
            any_win = 1'b1;
            winner  = OWN_D;
        end else if (bus.IF_REQ) begin
            any_win = 1'b1;
            winner  = OWN_IF;
        end
`endif
        if (!RST_N) begin
            any_win = 1'b0;
        end
    end

    assign if_gnt = any_win && (winner == OWN_IF);
    assign d_gnt  = any_win && (winner == OWN_D);

    // With no winner the DRAM address is parked on the last one used.
    assign mem_addr = !any_win        ? addr_q :
                      (winner == OWN_D) ? bus.D_ADDR[ADDR_W-1:0] : bus.IF_ADDR[ADDR_W-1:0];

    assign unused_addr_bits = ^{bus.IF_ADDR[REQ_ADDR_W-1:ADDR_W], bus.D_ADDR[REQ_ADDR_W-1:ADDR_W]};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            addr_q     <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            addr_q <= mem_addr;
            if (if_rvalid) if_rdata_q <= bus.MEM_RDATA;
            if (d_rvalid)  d_rdata_q  <= bus.MEM_RDATA;
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)       last_owner <= OWN_IF;
        else if (any_win) last_owner <= winner;
    end
`else
    // Counts consecutive cycles IF waited; saturates so IF keeps winning until served.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            starve_cnt <= '0;
        end else if (bus.IF_REQ && !if_gnt) begin
            if (!if_starved) starve_cnt <= starve_cnt + 1'b1;
        end else begin
            starve_cnt <= '0;
        end
    end
`endif

    assign tag_in.valid = any_win && !(winner == OWN_D && bus.D_WE);
    assign tag_in.owner = winner;

    mem_arb_rdpipe #(
        .DEPTH (RD_LAT)
    ) u_rdpipe (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .tag_in  (tag_in),
        .tag_out (tag_head)
    );

    assign if_rvalid = tag_head.valid && (tag_head.owner == OWN_IF);
    assign d_rvalid  = tag_head.valid && (tag_head.owner == OWN_D);

    assign bus.IF_GNT    = if_gnt;
    assign bus.D_GNT     = d_gnt;
    assign bus.MEM_ADDR  = mem_addr;
    assign bus.MEM_WDATA = bus.D_WDATA;
    assign bus.MEM_WE    = d_gnt && bus.D_WE;
    assign bus.IF_RVALID = if_rvalid;
    assign bus.D_RVALID  = d_rvalid;
    assign bus.IF_RDATA  = if_rvalid ? bus.MEM_RDATA : if_rdata_q;
    assign bus.D_RDATA   = d_rvalid  ? bus.MEM_RDATA : d_rdata_q;

endmodule
